// File: rtl/voice_mixer.sv
// rtl/voice_mixer.sv - per-voice waveform shaping and frame mixing for the DAC
// Sums gated voices over a 256-voice frame and emits one saturated offset-binary sample per frame.
module voice_mixer #(
    parameter int NUM_VOICES = 256,
    parameter int PHASE_W    = 10,
    parameter int OUT_W      = 16,
    parameter int GAIN_SHIFT = 6
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    input  logic [1:0]         i_pipeline_state,
    input  logic [7:0]         i_voice_index,
    input  logic [PHASE_W-1:0] i_phase,
    input  logic [1:0]         i_wave_sel,
    input  logic               i_gate_we,
    input  logic [7:0]         i_gate_voice,
    input  logic               i_gate_on,
    output logic [OUT_W-1:0]   o_dac_out,
    output logic               o_sample_valid,
    output logic [8:0]         o_active_count
);
    localparam int ACC_W = PHASE_W + 8;
    localparam int SH_W  = ACC_W + GAIN_SHIFT;

    logic [NUM_VOICES-1:0] gate_q, gate_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [8:0]            cnt_q, cnt_d;
    logic                  primed_q, primed_d;
    logic [OUT_W-1:0]      dac_q, dac_d;
    logic                  valid_q, valid_d;
    logic [8:0]            active_q, active_d;

    logic                  capture, in_range, contributes, frame_end;
    logic [7:0]            voice;
    logic [PHASE_W-2:0]    fold;
    logic [PHASE_W-1:0]    wave;
    logic [ACC_W-1:0]      sum;
    logic [SH_W-1:0]       shifted;
    logic [SH_W-OUT_W:0]   hi_bits;
    logic [OUT_W-1:0]      sat;

    // The dds delivers the phase of the voice two counts behind the shared index.
    assign capture     = (i_pipeline_state == 2'd1);
    assign voice       = i_voice_index - 8'd2;
    assign in_range    = ({1'b0, voice} < 9'(NUM_VOICES));
    assign contributes = capture && in_range && gate_q[voice];
    assign frame_end   = capture && ({1'b0, voice} == 9'(NUM_VOICES - 1));
    assign fold        = i_phase[PHASE_W-1] ? ~i_phase[PHASE_W-2:0] : i_phase[PHASE_W-2:0];

    // Subtracting half scale from an unsigned PHASE_W value is just an MSB flip.
    always_comb begin
        wave = '0;
        case (i_wave_sel)
            2'd0: wave = {~i_phase[PHASE_W-1], i_phase[PHASE_W-2:0]};
            2'd1: wave = i_phase[PHASE_W-1] ? {1'b0, {(PHASE_W-1){1'b1}}}
                                            : {1'b1, {(PHASE_W-1){1'b0}}};
            2'd2: wave = {~fold[PHASE_W-2], fold[PHASE_W-3:0], 1'b0};
            default: wave = '0;
        endcase
    end

    assign sum     = acc_q + (contributes ? {{8{wave[PHASE_W-1]}}, wave} : '0);
    assign shifted = {sum, {GAIN_SHIFT{1'b0}}};
    assign hi_bits = shifted[SH_W-1:OUT_W-1];

    always_comb begin
        sat = shifted[OUT_W-1:0];
        if (!((&hi_bits) || !(|hi_bits))) begin
            sat = shifted[SH_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    always_comb begin
        gate_d   = gate_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        primed_d = primed_q;
        dac_d    = dac_q;
        valid_d  = 1'b0;
        active_d = active_q;
        if (i_gate_we && ({1'b0, i_gate_voice} < 9'(NUM_VOICES))) begin
            gate_d[i_gate_voice] = i_gate_on;
        end
        if (capture && in_range && voice == 8'd0) begin
            primed_d = 1'b1;
        end
        if (frame_end) begin
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = primed_q;
            if (primed_q) begin
                dac_d    = {~sat[OUT_W-1], sat[OUT_W-2:0]};
                active_d = cnt_q + {8'd0, contributes};
            end
        end else if (capture) begin
            acc_d = sum;
            cnt_d = cnt_q + {8'd0, contributes};
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            gate_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            primed_q <= 1'b0;
            dac_q    <= {1'b1, {(OUT_W-1){1'b0}}};
            valid_q  <= 1'b0;
            active_q <= '0;
        end else begin
            gate_q   <= gate_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            dac_q    <= dac_d;
            valid_q  <= valid_d;
            active_q <= active_d;
        end
    end

    assign o_dac_out      = dac_q;
    assign o_sample_valid = valid_q;
    assign o_active_count = active_q;
endmodule

// File: tb/tb_voice_mixer.sv
// tb/tb_voice_mixer.sv - directed vector bench for voice_mixer
module tb_voice_mixer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  st;
    logic [7:0]  idx;
    logic [9:0]  phase;
    logic [1:0]  wave;
    logic        gwe;
    logic [7:0]  gv;
    logic        gon;
    logic [15:0] dac;
    logic        valid;
    logic [8:0]  acnt;
    logic [9:0]  phase_tab [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    voice_mixer dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_pipeline_state(st), .i_voice_index(idx),
        .i_phase(phase), .i_wave_sel(wave), .i_gate_we(gwe), .i_gate_voice(gv),
        .i_gate_on(gon), .o_dac_out(dac), .o_sample_valid(valid), .o_active_count(acnt)
    );

    typedef struct {
        logic [1:0]  ws;
        logic        all;
        logic [9:0]  ph;
        logic [15:0] exp_dac;
        logic [8:0]  exp_cnt;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Models the shared pipeline counter and the dds phase feed.
    task automatic tick();
        logic [7:0] vv;
        @(posedge clk);
        #1;
        if (st == 2'd0) idx = idx + 8'd1;
        st = st + 2'd1;
        vv = idx - 8'd2;
        phase = phase_tab[vv];
    endtask

    task automatic wait_pulse(output logic ok, output int cyc);
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 2100 && !ok; i++) begin
            tick();
            cyc++;
            if (valid) ok = 1'b1;
        end
    endtask

    task automatic set_gate(input logic [7:0] v, input logic on);
        gwe = 1'b1;
        gv  = v;
        gon = on;
        tick();
        gwe = 1'b0;
    endtask

    task automatic set_gates(input logic all);
        for (int i = 0; i < 256; i++) set_gate(8'(i), all || (i == 5));
    endtask

    task automatic fill_phase(input logic [9:0] p);
        for (int i = 0; i < 256; i++) phase_tab[i] = p;
    endtask

    initial begin
        logic ok;
        int   cyc;
        int   elapsed;
        logic found;
        logic [7:0] vv;

        vecs[0] = '{2'd0, 1'b0, 10'h300, 16'hC000, 9'd1};
        vecs[1] = '{2'd1, 1'b1, 10'h200, 16'hFFFF, 9'd256};
        vecs[2] = '{2'd1, 1'b1, 10'h000, 16'h0000, 9'd256};
        vecs[3] = '{2'd3, 1'b1, 10'h155, 16'h8000, 9'd256};
        vecs[4] = '{2'd0, 1'b1, 10'h201, 16'hC000, 9'd256};
        vecs[5] = '{2'd2, 1'b0, 10'h080, 16'h4000, 9'd1};
        vecs[6] = '{2'd2, 1'b0, 10'h300, 16'h7F80, 9'd1};
        vecs[7] = '{2'd0, 1'b0, 10'h000, 16'h0000, 9'd1};
        vecs[8] = '{2'd0, 1'b0, 10'h3FF, 16'hFFC0, 9'd1};

        rst_n = 1'b0; st = 2'd0; idx = 8'd0; phase = '0; wave = 2'd0;
        gwe = 1'b0; gv = 8'd0; gon = 1'b0;
        fill_phase(10'h000);
        repeat (3) @(posedge clk);
        #1;
        check("reset_dac", 32'(dac), 32'h8000);
        check("reset_valid", 32'(valid), 32'h0);
        check("reset_count", 32'(acnt), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            wave = vecs[k].ws;
            fill_phase(vecs[k].ph);
            set_gates(vecs[k].all);
            wait_pulse(ok, cyc);
            check($sformatf("v%0d_settle_pulse", k), 32'(ok), 32'h1);
            wait_pulse(ok, cyc);
            check($sformatf("v%0d_pulse", k), 32'(ok), 32'h1);
            check($sformatf("v%0d_dac", k), 32'(dac), 32'(vecs[k].exp_dac));
            check($sformatf("v%0d_count", k), 32'(acnt), 32'(vecs[k].exp_cnt));
            check($sformatf("v%0d_period", k), 32'(cyc), 32'd1024);
            tick();
            check($sformatf("v%0d_pulse_width", k), 32'(valid), 32'h0);
            check($sformatf("v%0d_dac_hold", k), 32'(dac), 32'(vecs[k].exp_dac));
        end

        // Gate-on written in the very cycle voice 7 is captured.
        wave = 2'd0;
        fill_phase(10'h300);
        for (int i = 0; i < 256; i++) set_gate(8'(i), 1'b0);
        wait_pulse(ok, cyc);
        check("same_cycle_align", 32'(ok), 32'h1);
        found = 1'b0;
        for (int i = 0; i < 1100 && !found; i++) begin
            vv = idx - 8'd2;
            if (st == 2'd1 && vv == 8'd7) found = 1'b1;
            else tick();
        end
        check("same_cycle_found_v7", 32'(found), 32'h1);
        set_gate(8'd7, 1'b1);
        wait_pulse(ok, cyc);
        check("same_cycle_pulse1", 32'(ok), 32'h1);
        check("same_cycle_count_old_gate", 32'(acnt), 32'd0);
        check("same_cycle_dac_old_gate", 32'(dac), 32'h8000);
        wait_pulse(ok, cyc);
        check("same_cycle_pulse2", 32'(ok), 32'h1);
        check("same_cycle_count_next", 32'(acnt), 32'd1);
        check("same_cycle_dac_next", 32'(dac), 32'hC000);

        // Reset mid-frame: outputs clear at once, first pulse only after a full frame.
        set_gates(1'b0);
        wait_pulse(ok, cyc);
        check("midreset_align", 32'(ok), 32'h1);
        repeat (500) tick();
        rst_n = 1'b0;
        #1;
        check("midreset_dac", 32'(dac), 32'h8000);
        check("midreset_valid", 32'(valid), 32'h0);
        check("midreset_count", 32'(acnt), 32'h0);
        repeat (3) tick();
        rst_n = 1'b1;
        set_gate(8'd5, 1'b1);
        wait_pulse(ok, cyc);
        elapsed = cyc + 1;
        check("midreset_pulse", 32'(ok), 32'h1);
        check("midreset_first_pulse_late", 32'(elapsed > 1024), 32'h1);
        check("midreset_dac_after", 32'(dac), 32'hC000);
        check("midreset_count_after", 32'(acnt), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
